// File: rtl/issue_queue.sv
// Instruction buffer plus in-order issue stage: a circular queue fed FETCH_W words per beat
// that issues up to ISSUE_W words per cycle, holding back later slots on intra-group hazards.

module iq_decode (
  input  logic [31:0] instr_i,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        wr_rd_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o,
  output logic        ctrl_o
);
  logic [6:0] op;
  logic       unused_bits;

  assign op          = instr_i[6:0];
  assign rd_o        = instr_i[11:7];
  assign rs1_o       = instr_i[19:15];
  assign rs2_o       = instr_i[24:20];
  assign wr_rd_o     = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                  7'b0010111, 7'b1101111, 7'b1100111};
  assign use_rs1_o   = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1100111};
  assign use_rs2_o   = op inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign ctrl_o      = op inside {7'b1100011, 7'b1101111, 7'b1100111};
  assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};
endmodule

module issue_queue #(
  parameter int          FETCH_W = 2,
  parameter int          ISSUE_W = 2,
  parameter int          DEPTH   = 8,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_valid,
  input  logic [FETCH_W*32-1:0]    fetch_instr,
  output logic                     fetch_ready,
  input  logic                     stall,
  input  logic                     flush,
  output logic [ISSUE_W*32-1:0]    issue_instr,
  output logic [ISSUE_W-1:0]       issue_valid,
  output logic                     split,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]                  mem_q [DEPTH];
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                count_q, count_d;
  logic [ISSUE_W-1:0][31:0]     issue_instr_q, issue_instr_d;
  logic [ISSUE_W-1:0]           issue_valid_q, issue_valid_d;
  logic                         split_q, split_d;

  logic [ISSUE_W-1:0][31:0]     head;
  logic [ISSUE_W-1:0][4:0]      rd, rs1, rs2;
  logic [ISSUE_W-1:0]           wr_rd, use_rs1, use_rs2, ctrl;
  logic [ISSUE_W-1:0]           elig;
  logic [CW-1:0]                n;
  logic                         ok, ok_prev, enq;
  logic                         unused_dec;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    assign head[k] = mem_q[rd_ptr_q + PW'(k)];
    iq_decode u_dec (
      .instr_i  (head[k]),
      .rd_o     (rd[k]),
      .rs1_o    (rs1[k]),
      .rs2_o    (rs2[k]),
      .wr_rd_o  (wr_rd[k]),
      .use_rs1_o(use_rs1[k]),
      .use_rs2_o(use_rs2[k]),
      .ctrl_o   (ctrl[k])
    );
  end

  // slot 0 never checks sources, the youngest slot never blocks anything
  assign unused_dec = ^{rs1[0], rs2[0], use_rs1[0], use_rs2[0],
                        wr_rd[ISSUE_W-1], ctrl[ISSUE_W-1]};

  assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_W);
  assign enq         = fetch_valid & fetch_ready & ~flush;

  always_comb begin
    elig    = '0;
    n       = '0;
    ok      = 1'b0;
    ok_prev = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      ok = ok_prev && (count_q > CW'(k));
      for (int j = 0; j < k; j++) begin
        if (ctrl[j]) ok = 1'b0;
        if (wr_rd[j] && (rd[j] != 5'd0) &&
            ((use_rs1[k] && rd[j] == rs1[k]) || (use_rs2[k] && rd[j] == rs2[k]) ||
             rd[j] == rd[k]))
          ok = 1'b0;
      end
      elig[k] = ok;
      ok_prev = ok;
      if (ok) n = n + CW'(1);
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    issue_instr_d = issue_instr_q;
    issue_valid_d = issue_valid_q;
    split_d       = 1'b0;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      issue_instr_d = {ISSUE_W{NOP}};
      issue_valid_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(FETCH_W);
      if (!stall) begin
        rd_ptr_d = rd_ptr_q + n[PW-1:0];
        for (int k = 0; k < ISSUE_W; k++)
          issue_instr_d[k] = elig[k] ? head[k] : NOP;
        issue_valid_d = elig;
        split_d       = (n != '0) && (n < CW'(ISSUE_W)) && (count_q > n);
      end
      count_d = count_q + (enq ? CW'(FETCH_W) : '0) - (stall ? '0 : n);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      issue_instr_q <= {ISSUE_W{NOP}};
      issue_valid_q <= '0;
      split_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      issue_instr_q <= issue_instr_d;
      issue_valid_q <= issue_valid_d;
      split_q       <= split_d;
    end
  end

  // storage carries no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (enq)
      for (int f = 0; f < FETCH_W; f++)
        mem_q[wr_ptr_q + PW'(f)] <= fetch_instr[f*32 +: 32];
  end

  assign issue_instr = issue_instr_q;
  assign issue_valid = issue_valid_q;
  assign split       = split_q;
  assign occupancy   = count_q;
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench: a queue-based reference model predicts each post-edge output set,
// and a monitor compares it against the DUT one cycle later.

module tb_issue_queue;
  localparam int          FW  = 2;
  localparam int          IW  = 2;
  localparam int          D   = 8;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              fetch_valid = 1'b0;
  logic [FW*32-1:0]  fetch_instr = '0;
  logic              fetch_ready;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [IW*32-1:0]  issue_instr;
  logic [IW-1:0]     issue_valid;
  logic              split;
  logic [3:0]        occupancy;

  issue_queue #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(D), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready), .stall(stall), .flush(flush), .issue_instr(issue_instr),
    .issue_valid(issue_valid), .split(split), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW*32-1:0] instr;
    logic [IW-1:0]    vld;
    logic             split;
    int               occ;
    logic             rdy;
  } exp_t;

  exp_t             exp_q[$];
  logic [31:0]      mq[$];
  logic [IW*32-1:0] m_instr = {IW{NOP}};
  logic [IW-1:0]    m_valid = '0;
  logic             m_split = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // older instruction o prevents younger y from issuing in the same group
  function automatic bit blocks(input logic [31:0] o, input logic [31:0] y);
    bit o_wr, y_r1, y_r2;
    o_wr = o[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                          7'b0010111, 7'b1101111, 7'b1100111};
    y_r1 = y[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
    y_r2 = y[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (o[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111}) return 1'b1;
    if (o_wr && o[11:7] != 5'd0 &&
        ((y_r1 && y[19:15] == o[11:7]) || (y_r2 && y[24:20] == o[11:7]) || y[11:7] == o[11:7]))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic int group_n();
    int n = 0;
    for (int k = 0; k < IW && k < mq.size(); k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < k; j++) if (blocks(mq[j], mq[k])) ok = 1'b0;
      if (!ok) break;
      n++;
    end
    return n;
  endfunction

  // drive one cycle and predict the state after the coming edge; taken = beat consumed
  task automatic cyc(input bit fv, input logic [FW*32-1:0] beat, input bit st, input bit fl,
                     output bit taken);
    exp_t e;
    bit   rdy;
    int   n;
    @(negedge clk);
    fetch_valid = fv; fetch_instr = beat; stall = st; flush = fl;
    rdy   = (D - mq.size()) >= FW;
    taken = fv && (rdy || fl);
    if (fl) begin
      mq.delete();
      m_instr = {IW{NOP}}; m_valid = '0; m_split = 1'b0;
    end else begin
      if (!st) begin
        n = group_n();
        m_instr = {IW{NOP}}; m_valid = '0;
        for (int k = 0; k < n; k++) begin
          m_instr[k*32 +: 32] = mq.pop_front();
          m_valid[k] = 1'b1;
        end
        m_split = (n >= 1) && (n < IW) && (mq.size() > 0);
      end else m_split = 1'b0;
      if (fv && rdy) for (int f = 0; f < FW; f++) mq.push_back(beat[f*32 +: 32]);
    end
    e.instr = m_instr; e.vld = m_valid; e.split = m_split;
    e.occ = mq.size(); e.rdy = (D - mq.size()) >= FW;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [31:0] s0, input logic [31:0] s1);
    bit t;
    cyc(1'b1, {s1, s0}, 1'b0, 1'b0, t);
  endtask

  task automatic idle(input int cnt, input bit st);
    bit t;
    for (int i = 0; i < cnt; i++) cyc(1'b0, '0, st, 1'b0, t);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rd, r1, r2;
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 8))
      0:       return {7'd0, r2, r1, 3'b000, rd, 7'b0110011};
      1, 2:    return {12'($urandom), r1, 3'b000, rd, 7'b0010011};
      3:       return {12'($urandom), r1, 3'b010, rd, 7'b0000011};
      4:       return {7'd0, r2, r1, 3'b010, 5'($urandom), 7'b0100011};
      5:       return {7'd0, r2, r1, 3'b000, 5'd0, 7'b1100011};
      6:       return {20'($urandom), rd, 7'b1101111};
      7:       return {12'($urandom), r1, 3'b000, rd, 7'b1100111};
      default: return {20'($urandom), rd, 7'b0110111};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_instr", 64'(issue_instr), 64'(e.instr));
        chk("issue_valid", 64'(issue_valid), 64'(e.vld));
        chk("split", 64'(split), 64'(e.split));
        chk("occupancy", 64'(occupancy), 64'(e.occ));
        chk("fetch_ready", 64'(fetch_ready), 64'(e.rdy));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [FW*32-1:0] pend;
    bit               have, taken, st, fl;
    int               seq;

    #1 reset = 1'b1;
    #2;
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_instr", 64'(issue_instr), {NOP, NOP});
    chk("rst_split", 64'(split), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ready", 64'(fetch_ready), 64'd1);

    beat(32'h00500093, 32'h00700193);          // independent pair
    idle(2, 1'b0);
    beat(32'h00500093, 32'h00108133);          // RAW on x1 splits the group
    idle(3, 1'b0);
    beat(32'h00000463, 32'h00700193);          // branch issues alone
    idle(3, 1'b0);

    // fill under stall with a source that holds its beat until accepted
    seq = 1; have = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (!have) begin
        pend = {NOP | (32'(seq + 1) << 20), NOP | (32'(seq) << 20)};
        seq += 2; have = 1'b1;
      end
      cyc(1'b1, pend, 1'b1, 1'b0, taken);
      if (taken) have = 1'b0;
    end
    idle(6, 1'b0);
    if (have) cyc(1'b1, pend, 1'b0, 1'b0, taken);
    idle(6, 1'b0);

    // flush with occupancy 6 and a beat on the input
    beat(32'h00100093, 32'h00200113);
    for (int i = 0; i < 2; i++) cyc(1'b1, {32'h00400213, 32'h00300193}, 1'b1, 1'b0, taken);
    cyc(1'b1, {32'h00600313, 32'h00500293}, 1'b0, 1'b1, taken);
    idle(2, 1'b0);

    // asynchronous reset mid-drain
    beat(32'h00100093, 32'h00200113);
    beat(32'h00300193, 32'h00400213);
    idle(1, 1'b0);
    fetch_valid = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(issue_valid), 64'd0);
    chk("arst_instr", 64'(issue_instr), {NOP, NOP});
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_split", 64'(split), 64'd0);
    mq.delete(); m_instr = {IW{NOP}}; m_valid = '0; m_split = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    have = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!have && $urandom_range(0, 9) < 7) begin
        for (int f = 0; f < FW; f++) pend[f*32 +: 32] = rnd_instr();
        have = 1'b1;
      end
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 39) == 0);
      cyc(have, pend, st, fl, taken);
      if (taken) have = 1'b0;
    end
    idle(8, 1'b0);
    @(posedge clk); #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
